// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port video RAM between the scanout reader
// and the game-logic writer. Scanout has priority. The writer is limited to
// a blanking write window, and a starvation override guarantees it progress.
// A registered frame tick marks the start of vertical blanking.
`timescale 1ns/1ps
module vram_arbiter #(
  parameter int ADDR_W        = 12,
  parameter int DATA_W        = 8,
  parameter int STARVE_MAX    = 15,
  parameter int WR_IN_VISIBLE = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              visible_i,
  input  logic [9:0]        position_x_i,
  input  logic [9:0]        position_y_i,
  input  logic              scan_req_i,
  input  logic [ADDR_W-1:0] scan_addr_i,
  output logic [DATA_W-1:0] scan_rdata_o,
  output logic              scan_valid_o,
  output logic              scan_miss_o,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_gnt_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              frame_tick_o
);

  typedef enum logic [1:0] {
    OWN_IDLE,
    OWN_SCAN,
    OWN_WRITE,
    OWN_OVERRIDE
  } own_t;

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  own_t       own_d;
  own_t       own_q;
  logic [7:0] starve_q;
  logic       win;
  logic       override;

  // Write window and starvation override qualification
  always_comb begin
    win      = ~visible_i | (WR_IN_VISIBLE != 0);
    override = wr_req_i & (starve_q == STARVE_LIM);
  end

  // Per-cycle owner decision in priority order
  always_comb begin
    own_d = OWN_IDLE;
    if (override) begin
      own_d = OWN_OVERRIDE;
    end else if (scan_req_i) begin
      own_d = OWN_SCAN;
    end else if (wr_req_i & win) begin
      own_d = OWN_WRITE;
    end
  end

  // RAM-side controls and grant/miss flags, all forced low while in reset
  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    wr_gnt_o    = 1'b0;
    scan_miss_o = 1'b0;
    if (!rst_i) begin
      unique case (own_d)
        OWN_SCAN: begin
          ram_en_o   = 1'b1;
          ram_addr_o = scan_addr_i;
        end
        OWN_WRITE, OWN_OVERRIDE: begin
          ram_en_o    = 1'b1;
          ram_we_o    = 1'b1;
          ram_addr_o  = wr_addr_i;
          ram_wdata_o = wr_data_i;
          wr_gnt_o    = 1'b1;
          scan_miss_o = (own_d == OWN_OVERRIDE) & scan_req_i;
        end
        default: ;
      endcase
    end
  end

  // Read data return; the valid flag is the registered owner being SCAN
  always_comb begin
    scan_valid_o = (own_q == OWN_SCAN);
    scan_rdata_o = rst_i ? '0 : ram_rdata_i;
  end

  // Starvation counter: counts denied request cycles, saturating
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_q <= '0;
    end else if (wr_req_i & ~wr_gnt_o) begin
      starve_q <= (starve_q >= STARVE_LIM) ? STARVE_LIM : starve_q + 8'd1;
    end else begin
      starve_q <= '0;
    end
  end

  // Owner register (also carries read-valid) and frame tick at (0,480)
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      own_q        <= OWN_IDLE;
      frame_tick_o <= 1'b0;
    end else begin
      own_q        <= own_d;
      frame_tick_o <= (position_x_i == 10'd0) & (position_y_i == 10'd480);
    end
  end

endmodule
